// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard driving data/control hazard stalls
// Optional perf counters perfStallCycles/perfFlushCount are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int NUM_REGS      = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int ALU_LAT       = 1,
  parameter int LOAD_LAT      = 2,
  parameter int BR_EXTRA      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idValid,
  input  logic [REG_NUM_WIDTH-1:0] idRS,
  input  logic [REG_NUM_WIDTH-1:0] idRT,
  input  logic                     idRSUsed,
  input  logic                     idRTUsed,
  input  logic                     idIsBranch,
  input  logic [REG_NUM_WIDTH-1:0] idRD,
  input  logic                     idRfWrEnable,
  input  logic                     idIsLoad,
  input  logic                     brTaken,
  input  logic                     pipeFlush,
  output logic                     dHazard,
  output logic                     cHazard,
  output logic [NUM_REGS-1:0]      busyMask
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]              perfStallCycles,
  output logic [31:0]              perfFlushCount
`endif
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] ALU_C  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] BR_THR = CNT_W'(BR_EXTRA);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic [CNT_W-1:0] thr;
  logic             hazard_raw;
  logic             issue;

  // Index 0 is never matched, so r0 always reads back as not pending.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (idRS == REG_NUM_WIDTH'(r)) rs_cnt = cnt_q[r];
      if (idRT == REG_NUM_WIDTH'(r)) rt_cnt = cnt_q[r];
    end
  end

  assign thr        = idIsBranch ? '0 : BR_THR;
  assign hazard_raw = idValid & ((idRSUsed & (rs_cnt > thr)) | (idRTUsed & (rt_cnt > thr)));
  assign issue      = idValid & ~hazard_raw & ~pipeFlush;
  assign dHazard    = ~rst & hazard_raw;
  assign cHazard    = ~rst & idValid & brTaken & ~hazard_raw;

  always_comb begin
    busyMask = '0;
    if (!rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        busyMask[r] = (cnt_q[r] != '0);
      end
    end
  end

  // Youngest writer overwrites any older pending countdown on the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = '0;
    end
    if (!pipeFlush) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - 1'b1;
        if (issue && idRfWrEnable && (idRD == REG_NUM_WIDTH'(r))) begin
          cnt_d[r] = idIsLoad ? LOAD_C : ALU_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) cnt_q[r] <= '0;
      else     cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  assign stall_d = stall_q + {31'd0, dHazard};
  assign flush_d = flush_q + {31'd0, cHazard};

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perfStallCycles = stall_q;
  assign perfFlushCount  = flush_q;
`endif

endmodule
